// File: rtl/car_queue_dispatch.sv
// Per-lane waiting-car queue with a one-at-a-time launch handshake toward the
// left-turn car animator. Tracks queue depth and flags refused arrivals and
// decrements seen on an empty queue.
//
// state   | meaning
// IDLE    | no launch outstanding; request when go and queue not empty
// REQUEST | add_car high, waiting for the animator's decrement_car
// GAP     | post-launch spacing, GAP_CYCLES cycles before re-arming
module car_queue_dispatch #(
  parameter int MAX_CARS   = 7,
  parameter int CNT_W      = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic             traffic_clk,
  input  logic             reset,
  input  logic             car_arrive,
  input  logic             go,
  input  logic             decrement_car,
  output logic             add_car,
  output logic [CNT_W-1:0] car_count,
  output logic             queue_full,
  output logic             queue_empty,
  output logic             dropped_car,
  output logic             underflow_err
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CARS);
  localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] gap_cnt;

  assign queue_full  = (car_count == MAX_CNT);
  assign queue_empty = (car_count == '0);

  // A simultaneous arrival and departure cancel out with no side effects.
  always_ff @(posedge traffic_clk or negedge reset) begin
    if (!reset) begin
      car_count     <= '0;
      dropped_car   <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      dropped_car <= 1'b0;
      if (car_arrive && !decrement_car) begin
        if (car_count != MAX_CNT) car_count <= car_count + 1'b1;
        else                      dropped_car <= 1'b1;
      end else if (decrement_car && !car_arrive) begin
        if (car_count != '0) car_count <= car_count - 1'b1;
        else                 underflow_err <= 1'b1;
      end
    end
  end

  // add_car is registered alongside state so it is high exactly in REQUEST.
  always_ff @(posedge traffic_clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
      add_car <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (decrement_car) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
            add_car <= 1'b0;
          end else if (go && car_count != '0) begin
            state   <= REQUEST;
            add_car <= 1'b1;
          end
        end
        REQUEST: begin
          if (decrement_car) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
            add_car <= 1'b0;
          end else if (!go) begin
            state   <= IDLE;
            add_car <= 1'b0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt <= 4'd1) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          gap_cnt <= '0;
          add_car <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_car_queue_dispatch.sv
// Directed bench for car_queue_dispatch with an inline model of the animator
// (decrement_car one cycle after it samples add_car high).
module tb_car_queue_dispatch;

  logic       traffic_clk = 1'b0;
  logic       reset;
  logic       car_arrive;
  logic       go;
  logic       decrement_car;
  logic       add_car;
  logic [2:0] car_count;
  logic       queue_full;
  logic       queue_empty;
  logic       dropped_car;
  logic       underflow_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int drop_cnt = 0;
  bit anim_on = 1'b0;

  int nl;
  int dcyc [4];
  int dcnt [4];
  int extra_dec;
  int extra_add;

  car_queue_dispatch #(.MAX_CARS(7), .CNT_W(3), .GAP_CYCLES(2)) dut (
    .traffic_clk  (traffic_clk),
    .reset        (reset),
    .car_arrive   (car_arrive),
    .go           (go),
    .decrement_car(decrement_car),
    .add_car      (add_car),
    .car_count    (car_count),
    .queue_full   (queue_full),
    .queue_empty  (queue_empty),
    .dropped_car  (dropped_car),
    .underflow_err(underflow_err)
  );

  always #5 traffic_clk = ~traffic_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, advance past posedge, then model the animator.
  task automatic tick();
    logic a;
    @(negedge traffic_clk);
    a = add_car;
    if (dropped_car) drop_cnt++;
    @(posedge traffic_clk);
    #1;
    cyc++;
    if (anim_on) decrement_car = a && !decrement_car;
  endtask

  task automatic pulse_arrive();
    car_arrive = 1'b1;
    tick();
    car_arrive = 1'b0;
  endtask

  task automatic pulse_dec();
    decrement_car = 1'b1;
    tick();
    decrement_car = 1'b0;
  endtask

  initial begin
    reset = 1'b0; car_arrive = 1'b0; go = 1'b0; decrement_car = 1'b0;
    #2;
    chk("rst_count", car_count, 0);
    chk("rst_add", add_car, 0);
    chk("rst_empty", queue_empty, 1);
    chk("rst_full", queue_full, 0);
    chk("rst_uflow", underflow_err, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Three arrivals with the light red.
    pulse_arrive(); pulse_arrive(); pulse_arrive();
    tick();
    chk("arr3_count", car_count, 3);
    chk("arr3_add", add_car, 0);
    chk("arr3_empty", queue_empty, 0);

    // Green light drains the queue through the animator model.
    nl = 0;
    anim_on = 1'b1;
    go = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (decrement_car && nl < 4) begin
        dcyc[nl] = cyc;
        dcnt[nl] = car_count;
        nl++;
      end
    end
    chk("launch_n", nl, 3);
    chk("launch_sp1", dcyc[1] - dcyc[0], 5);
    chk("launch_sp2", dcyc[2] - dcyc[1], 5);
    chk("launch_c0", dcnt[0], 3);
    chk("launch_c1", dcnt[1], 2);
    chk("launch_c2", dcnt[2], 1);
    chk("drain_count", car_count, 0);
    chk("drain_add", add_car, 0);
    chk("drain_empty", queue_empty, 1);
    anim_on = 1'b0;
    go = 1'b0;
    decrement_car = 1'b0;
    tick();

    // Saturation: nine arrivals into a capacity-7 queue.
    drop_cnt = 0;
    for (int i = 0; i < 9; i++) pulse_arrive();
    tick(); tick();
    chk("sat_count", car_count, 7);
    chk("sat_full", queue_full, 1);
    chk("sat_drops", drop_cnt, 2);

    // Bring the count down to 4, then collide an arrival with a departure.
    pulse_dec(); pulse_dec(); pulse_dec();
    repeat (4) tick();
    chk("dec3_count", car_count, 4);
    drop_cnt = 0;
    car_arrive = 1'b1; decrement_car = 1'b1;
    tick();
    car_arrive = 1'b0; decrement_car = 1'b0;
    tick(); tick();
    chk("both_count", car_count, 4);
    chk("both_drop", drop_cnt, 0);
    chk("both_uflow", underflow_err, 0);
    repeat (4) tick();

    // go falls on the same edge the animator accepts the request.
    go = 1'b1;
    tick();
    chk("gd_req", add_car, 1);
    anim_on = 1'b1;
    go = 1'b0;
    tick();
    chk("gd_idle_add", add_car, 0);
    chk("gd_idle_cnt", car_count, 4);
    chk("gd_dec", decrement_car, 1);
    tick();
    chk("gd_after_cnt", car_count, 3);
    chk("gd_after_add", add_car, 0);
    extra_dec = 0; extra_add = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (decrement_car) extra_dec++;
      if (add_car) extra_add++;
    end
    chk("gd_no_dec", extra_dec, 0);
    chk("gd_no_add", extra_add, 0);
    chk("gd_final_cnt", car_count, 3);
    anim_on = 1'b0;
    decrement_car = 1'b0;

    // Drain to zero, then a spurious decrement.
    pulse_dec(); pulse_dec(); pulse_dec();
    repeat (4) tick();
    chk("pre_uf_cnt", car_count, 0);
    chk("pre_uf_flag", underflow_err, 0);
    pulse_dec();
    tick();
    chk("uf_cnt", car_count, 0);
    chk("uf_flag", underflow_err, 1);
    chk("uf_empty", queue_empty, 1);
    pulse_arrive(); pulse_arrive();
    tick();
    chk("uf_sticky", underflow_err, 1);
    chk("uf_arr_cnt", car_count, 2);

    // Reset asserted mid-GAP clears everything without a clock edge.
    pulse_dec();
    chk("gap_cnt", car_count, 1);
    reset = 1'b0;
    #1;
    chk("rgap_count", car_count, 0);
    chk("rgap_uflow", underflow_err, 0);
    chk("rgap_empty", queue_empty, 1);
    chk("rgap_full", queue_full, 0);
    chk("rgap_add", add_car, 0);
    chk("rgap_drop", dropped_car, 0);
    #1;
    reset = 1'b1;
    tick();

    // Reset asserted mid-REQUEST drops add_car immediately.
    pulse_arrive();
    go = 1'b1;
    tick();
    chk("rreq_pre_add", add_car, 1);
    reset = 1'b0;
    #1;
    chk("rreq_add", add_car, 0);
    chk("rreq_count", car_count, 0);
    go = 1'b0;
    #1;
    reset = 1'b1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/car_queue_dispatch.md
Name: car_queue_dispatch

Overview:
- Per-lane waiting-car queue and launch controller. It sits directly upstream of the left-turn car animators.
- Counts arriving cars, shows the queue depth on the board display, and requests one car launch at a time while the lane's light is green.
- Drives the animator's add_car input. Consumes the animator's decrement_car pulse to remove the launched car from the queue.

Parameters:
- MAX_CARS, 7: queue capacity; count saturates here.
- CNT_W, 3: width of car_count; must satisfy 2^CNT_W > MAX_CARS.
- GAP_CYCLES, 2: idle cycles after each accepted launch before a new request; range 1..15.

Ports:
- traffic_clk  input  1  traffic-rate clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- car_arrive  input  1  one-cycle pulse: a new car joins the queue.
- go  input  1  lane light permits movement (green), level.
- decrement_car  input  1  one-cycle pulse from the animator: a car has left the queue.
- add_car  output  1  launch request to the animator, registered.
- car_count  output  CNT_W  current queue depth, for display.
- queue_full  output  1  car_count == MAX_CARS.
- queue_empty  output  1  car_count == 0.
- dropped_car  output  1  one-cycle pulse: an arrival was refused because the queue was full.
- underflow_err  output  1  sticky: decrement_car was received with car_count == 0.

Behaviour:
- Reset (reset low, asynchronous):
  - car_count=0, add_car=0, dropped_car=0, underflow_err=0.
  - FSM=IDLE, gap counter=0.
  - queue_empty=1 and queue_full=0 during reset; both are combinational from car_count.
- Count update, evaluated every cycle with priority on simultaneous events:
  - arrive && dec: count unchanged, no dropped_car, no error.
  - arrive only, count<MAX_CARS: count+1.
  - arrive only, count==MAX_CARS: count held, dropped_car=1 next cycle.
  - dec only, count>0: count-1.
  - dec only, count==0: count held at 0, underflow_err set to 1; it clears only on reset.
- FSM states: IDLE, REQUEST, GAP. add_car is 1 exactly when FSM==REQUEST.
  - IDLE:
    - decrement_car → GAP. This is the late accept after an aborted request.
    - else go && count!=0 → REQUEST.
    - else stay in IDLE.
  - REQUEST:
    - decrement_car → GAP, gap counter loaded with GAP_CYCLES.
    - else !go → IDLE; the request is aborted.
    - else stay in REQUEST.
    - Count reaching 0 from an external source does not abort the request; only decrement_car or !go leaves REQUEST.
  - GAP:
    - gap counter decrements each cycle; at 1 → IDLE.
    - decrement_car received in GAP still updates count (and raises underflow_err if count==0); the FSM does not change.
  - Entry to GAP from IDLE also loads GAP_CYCLES.
- Nominal launch timing, with the animator sampling add_car in its ready state:
  - t0: REQUEST, add_car=1.
  - t1: decrement_car=1; add_car still 1 (the animator ignores it in this cycle).
  - t2..t(1+GAP_CYCLES): GAP, add_car=0.
  - Next: IDLE, then REQUEST if still eligible.
  - Launch rate at default GAP_CYCLES=2 is one car per 5 cycles, which is at or slower than the animator's 4-cycle acceptance period.
- go falling in the same cycle that the animator samples add_car=1: the FSM returns to IDLE, the animator's decrement_car arrives the next cycle, the count is decremented and the FSM enters GAP. Exactly one car is removed.
- Reset asserted mid-request: add_car drops immediately (asynchronously) and all state clears.

Test Plan:
- Reset, 3 car_arrive pulses with go=0 → car_count=3, add_car stays 0, queue_empty=0.
- go=1 with count=3 and a model animator (decrement_car 1 cycle after sampling add_car) → 3 launches spaced 5 cycles apart; car_count 3→2→1→0; add_car=0 afterwards; queue_empty=1.
- 9 arrivals with go=0 → car_count saturates at 7, queue_full=1, exactly 2 dropped_car pulses.
- car_arrive and decrement_car in the same cycle at count=4 → count stays 4, no dropped_car, underflow_err=0.
- go drops on the same edge the animator accepts → FSM goes IDLE, decrement_car next cycle, count decrements by exactly 1, FSM enters GAP, no second launch.
- Spurious decrement_car at count=0 → count stays 0, underflow_err=1 and persists; assert reset low mid-GAP → all outputs return to reset values without waiting for a clock edge.
